// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC capture path
//
// Purpose: state/channel enums and constants used by adc_capture and its
// frame interface. No ports.
package adc_pkg;

  // Default bits captured per channel.
  localparam int SAMPLE_W_DEFAULT = 16;

  // Pole position of the optional DC blocker: y_prev is leaked by y_prev/2^8.
  localparam int DCB_SHIFT = 8;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SKIP,
    SHIFT,
    WAIT
  } adc_state_t;

  typedef enum logic {
    CH_LEFT,
    CH_RIGHT
  } adc_ch_t;

endpackage

// File: rtl/adc_capture_if.sv
// rtl/adc_capture_if.sv - stereo frame valid/ready interface
//
// Purpose: carries one captured stereo frame to the consumer.
// Signals:
//   LDATA, RDATA : SAMPLE_W-bit two's complement left/right samples
//   out_valid    : LDATA/RDATA hold a new frame
//   out_ready    : consumer accepts the frame
// Modports: master (capture side), slave (consumer side).
interface adc_capture_if
  import adc_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
);

  logic [SAMPLE_W-1:0] LDATA;
  logic [SAMPLE_W-1:0] RDATA;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output LDATA,
    output RDATA,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  LDATA,
    input  RDATA,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop input synchronizer with edge detection
//
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized 0->1 / 1->0 transitions
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  // Fewer than two flops is not a synchronizer; clamp silently.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] chain;
  logic         prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[N-2:0], d};
      prev  <= chain[N-1];
    end
  end

  assign level = chain[N-1];
  assign rise  = chain[N-1] & ~prev;
  assign fall  = ~chain[N-1] & prev;

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - codec ADC serial stream to parallel stereo frames
//
// Purpose: deserializes AUD_ADCDAT (framed by AUD_BCLK / AUD_ADCLRCK, codec is
// bit-clock master) into left/right samples in the Clk domain and presents
// each stereo frame on a valid/ready interface.
// Ports:
//   Clk, Reset_n      : system clock, asynchronous active-low reset
//   Enable           : capture enable, low forces IDLE
//   AUD_BCLK         : codec bit clock (sampled, never used as a clock)
//   AUD_ADCLRCK      : frame clock, low = left, high = right
//   AUD_ADCDAT       : serial data, MSB first
//   frame            : adc_capture_if master (LDATA, RDATA, out_valid, out_ready)
//   overrun          : sticky, a frame was overwritten before acceptance
//   short_word       : sticky, a channel ended before SAMPLE_W bits arrived
// Optional build macro: ADC_DCBLOCK_EN inserts a one-pole DC blocker per
// channel ahead of LDATA/RDATA (one extra Clk of latency).
module adc_capture
  import adc_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
  parameter int I2S_DELAY   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Enable,
  input  logic          AUD_BCLK,
  input  logic          AUD_ADCLRCK,
  input  logic          AUD_ADCDAT,
  adc_capture_if.master frame,
  output logic          overrun,
  output logic          short_word
);

  localparam int CW  = $clog2(SAMPLE_W + 1);
  localparam int SKW = (I2S_DELAY < 1) ? 1 : $clog2(I2S_DELAY + 1);

  // ---------------------------------------------------------------- inputs
  logic bclk_lvl, bclk_rise, bclk_fall;
  logic lrck_lvl, lrck_rise, lrck_fall;
  logic dat_lvl, dat_rise, dat_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(Clk), .rst_n(Reset_n), .d(AUD_BCLK),
    .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk(Clk), .rst_n(Reset_n), .d(AUD_ADCLRCK),
    .level(lrck_lvl), .rise(lrck_rise), .fall(lrck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(Clk), .rst_n(Reset_n), .d(AUD_ADCDAT),
    .level(dat_lvl), .rise(dat_rise), .fall(dat_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{bclk_lvl, bclk_fall, lrck_rise, lrck_fall, dat_rise, dat_fall};

  // LRCK is only meaningful as seen by the codec's bit clock, so its edges
  // are judged against the value held at the previous BCLK rise.
  logic lrck_last;
  logic lrck_edge;
  assign lrck_edge = bclk_rise && (lrck_lvl != lrck_last);

  // ---------------------------------------------------------------- FSM
  adc_state_t          state_q, state_d;
  adc_ch_t             ch_q, ch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SKW-1:0]      skip_q, skip_d;
  logic [SAMPLE_W-1:0] sr_q, sr_d;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [SAMPLE_W-1:0] store_word;
  logic                store_en, short_set, start, shift_in;
  logic                frame_done;
  logic                short_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      ch_q       <= CH_LEFT;
      cnt_q      <= '0;
      skip_q     <= '0;
      sr_q       <= '0;
      lrck_last  <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      frame_done <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      sr_q       <= sr_d;
      frame_done <= 1'b0;
      if (bclk_rise) lrck_last <= lrck_lvl;
      if (short_set) short_q <= 1'b1;
      if (store_en) begin
        if (ch_q == CH_LEFT) begin
          hold_l <= store_word;
        end else begin
          hold_r     <= store_word;
          frame_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;
    sr_d       = sr_q;
    store_en   = 1'b0;
    store_word = '0;
    short_set  = 1'b0;
    start      = 1'b0;
    shift_in   = 1'b0;

    if (!Enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = ALIGN;
        ALIGN: if (lrck_edge && !lrck_lvl) start = 1'b1;
        SKIP: begin
          if (lrck_edge) begin
            start = 1'b1;
          end else if (bclk_rise) begin
            if (skip_q >= SKW'(I2S_DELAY)) shift_in = 1'b1;
            else skip_d = skip_q + SKW'(1);
          end
        end
        SHIFT: begin
          if (lrck_edge) begin
            // Channel ended early: left-align what arrived, zero the LSBs.
            store_en   = 1'b1;
            store_word = sr_q << (CW'(SAMPLE_W) - cnt_q);
            short_set  = 1'b1;
            start      = 1'b1;
          end else if (bclk_rise) begin
            shift_in = 1'b1;
          end
        end
        WAIT:    if (lrck_edge) start = 1'b1;
        default: state_d = IDLE;
      endcase

      // The rise that reveals the LRCK edge is the first delay slot; with
      // no delay it already carries the MSB.
      if (start) begin
        ch_d   = lrck_lvl ? CH_RIGHT : CH_LEFT;
        sr_d   = '0;
        cnt_d  = '0;
        skip_d = SKW'(1);
        if (I2S_DELAY == 0) shift_in = 1'b1;
        else state_d = SKIP;
      end

      if (shift_in) begin
        sr_d    = {sr_d[SAMPLE_W-2:0], dat_lvl};
        cnt_d   = cnt_d + CW'(1);
        state_d = SHIFT;
        if (cnt_d == CW'(SAMPLE_W)) begin
          store_en   = 1'b1;
          store_word = sr_d;
          state_d    = WAIT;
        end
      end
    end
  end

  // ---------------------------------------------------------------- output path
  logic                load_en;
  logic [SAMPLE_W-1:0] load_l, load_r;

`ifdef ADC_DCBLOCK_EN
  // y = x - x_prev + y_prev - (y_prev >>> DCB_SHIFT), saturated to SAMPLE_W.
  function automatic logic signed [SAMPLE_W-1:0] dcb_step(
    input logic signed [SAMPLE_W-1:0] x,
    input logic signed [SAMPLE_W-1:0] xp,
    input logic signed [SAMPLE_W-1:0] yp
  );
    logic signed [SAMPLE_W+1:0] xe, xpe, ype, acc;
    xe  = {{2{x[SAMPLE_W-1]}}, x};
    xpe = {{2{xp[SAMPLE_W-1]}}, xp};
    ype = {{2{yp[SAMPLE_W-1]}}, yp};
    acc = xe - xpe + ype - (ype >>> DCB_SHIFT);
    if (acc[SAMPLE_W+1:SAMPLE_W-1] == 3'b000 || acc[SAMPLE_W+1:SAMPLE_W-1] == 3'b111)
      return acc[SAMPLE_W-1:0];
    else if (acc[SAMPLE_W+1])
      return {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  logic signed [SAMPLE_W-1:0] xl_q, xr_q, yl_q, yr_q;
  logic signed [SAMPLE_W-1:0] yl_d, yr_d;
  logic                       filt_done;

  assign yl_d = dcb_step($signed(hold_l), xl_q, yl_q);
  assign yr_d = dcb_step($signed(hold_r), xr_q, yr_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      xl_q      <= '0;
      xr_q      <= '0;
      yl_q      <= '0;
      yr_q      <= '0;
      filt_done <= 1'b0;
    end else begin
      filt_done <= frame_done;
      if (frame_done) begin
        xl_q <= $signed(hold_l);
        xr_q <= $signed(hold_r);
        yl_q <= yl_d;
        yr_q <= yr_d;
      end
    end
  end

  assign load_en = filt_done;
  assign load_l  = yl_q;
  assign load_r  = yr_q;
`else
  assign load_en = frame_done;
  assign load_l  = hold_l;
  assign load_r  = hold_r;
`endif

  logic [SAMPLE_W-1:0] ldata_q, rdata_q;
  logic                valid_q, overrun_q;

  // A frame landing on the acceptance edge simply replaces the accepted one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ldata_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (load_en) begin
      ldata_q <= load_l;
      rdata_q <= load_r;
      valid_q <= 1'b1;
      if (valid_q && !frame.out_ready) overrun_q <= 1'b1;
    end else if (valid_q && frame.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign frame.LDATA     = ldata_q;
  assign frame.RDATA     = rdata_q;
  assign frame.out_valid = valid_q;
  assign overrun         = overrun_q;
  assign short_word      = short_q;

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - directed bench for adc_capture (default build)
module tb_adc_capture;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Enable = 1'b0;
  logic bclk = 1'b0;
  logic lrck = 1'b1;
  logic dat = 1'b0;
  logic overrun, short_word;

  adc_capture_if #(.SAMPLE_W(16)) intf ();

  adc_capture #(.SAMPLE_W(16), .I2S_DELAY(1), .SYNC_STAGES(2)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Enable     (Enable),
    .AUD_BCLK   (bclk),
    .AUD_ADCLRCK(lrck),
    .AUD_ADCDAT (dat),
    .frame      (intf),
    .overrun    (overrun),
    .short_word (short_word)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Frame monitor: sampled on the falling edge, away from DUT updates.
  int          pulses = 0;
  int          valid_rise_cyc = 0;
  int          last_rise = 0;
  logic        valid_prev = 1'b0;
  logic [15:0] cap_l = '0, cap_r = '0;

  always @(negedge Clk) begin
    if (intf.out_valid === 1'b1 && !valid_prev) begin
      pulses         = pulses + 1;
      valid_rise_cyc = cyc;
      cap_l          = intf.LDATA;
      cap_r          = intf.RDATA;
    end
    valid_prev = (intf.out_valid === 1'b1);
  end

  logic [15:0] snap_l, snap_r;
  logic        snap_v, snap_ov, snap_sw;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One channel: slot 0 carries the LRCK change (I2S delay bit), slots
  // 1..nbits carry the top nbits of word MSB first, one pad slot follows.
  // Data and LRCK change on the BCLK fall; BCLK is Clk/16.
  task automatic send_channel(input logic lr, input logic [15:0] word, input int nbits,
                              input int en_slot, input int rst_slot);
    for (int s = 0; s < nbits + 2; s++) begin
      @(posedge Clk);
      #1;
      bclk = 1'b0;
      if (s == 0) lrck = lr;
      dat = (s >= 1 && s <= nbits) ? word[16-s] : 1'b0;
      if (s == en_slot) Enable = 1'b1;
      if (s == rst_slot) begin
        #2;
        Reset_n = 1'b0;
        #1;
        snap_l  = intf.LDATA;
        snap_r  = intf.RDATA;
        snap_v  = intf.out_valid;
        snap_ov = overrun;
        snap_sw = short_word;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
      end
      repeat (8) @(posedge Clk);
      #1;
      bclk = 1'b1;
      if (s == nbits) last_rise = cyc;
      repeat (7) @(posedge Clk);
    end
  endtask

  initial begin
    intf.out_ready = 1'b1;

    // Reset state
    tick(3);
    check("rst_ldata", intf.LDATA, 16'h0000);
    check("rst_rdata", intf.RDATA, 16'h0000);
    check("rst_valid", {15'd0, intf.out_valid}, 16'd0);
    check("rst_overrun", {15'd0, overrun}, 16'd0);
    check("rst_short", {15'd0, short_word}, 16'd0);
    Reset_n = 1'b1;
    tick(3);

    // Basic I2S frame with consumer always ready
    Enable = 1'b1;
    pulses = 0;
    send_channel(1'b1, 16'h0000, 16, -1, -1);
    send_channel(1'b0, 16'hA5C3, 16, -1, -1);
    send_channel(1'b1, 16'h0F0F, 16, -1, -1);
    tick(4);
    check("t1_pulses", 16'(pulses), 16'd1);
    check("t1_ldata", cap_l, 16'hA5C3);
    check("t1_rdata", cap_r, 16'h0F0F);
    check("t1_latency", 16'(valid_rise_cyc - last_rise), 16'd4);
    check("t1_valid_drop", {15'd0, intf.out_valid}, 16'd0);

    // Enable raised mid-right: the partial frame must be discarded
    Enable = 1'b0;
    tick(2);
    pulses = 0;
    send_channel(1'b0, 16'h1111, 16, -1, -1);
    send_channel(1'b1, 16'hEEEE, 16, 5, -1);
    send_channel(1'b0, 16'h2222, 16, -1, -1);
    send_channel(1'b1, 16'h3333, 16, -1, -1);
    tick(4);
    check("t2_pulses", 16'(pulses), 16'd1);
    check("t2_ldata", cap_l, 16'h2222);
    check("t2_rdata", cap_r, 16'h3333);

    // Consumer stalled across two frames
    intf.out_ready = 1'b0;
    send_channel(1'b0, 16'h1234, 16, -1, -1);
    send_channel(1'b1, 16'h5678, 16, -1, -1);
    check("t3_no_overrun_yet", {15'd0, overrun}, 16'd0);
    check("t3_first_rdata", intf.RDATA, 16'h5678);
    send_channel(1'b0, 16'h9ABC, 16, -1, -1);
    send_channel(1'b1, 16'hDEF0, 16, -1, -1);
    check("t3_valid_held", {15'd0, intf.out_valid}, 16'd1);
    check("t3_ldata", intf.LDATA, 16'h9ABC);
    check("t3_rdata", intf.RDATA, 16'hDEF0);
    check("t3_overrun", {15'd0, overrun}, 16'd1);
    @(posedge Clk);
    #1;
    intf.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    intf.out_ready = 1'b0;
    check("t3_accept", {15'd0, intf.out_valid}, 16'd0);

    // Short right channel of 12 ones
    intf.out_ready = 1'b1;
    pulses = 0;
    check("t4_short_before", {15'd0, short_word}, 16'd0);
    send_channel(1'b0, 16'h4321, 16, -1, -1);
    send_channel(1'b1, 16'hFFF0, 12, -1, -1);
    send_channel(1'b0, 16'h0000, 16, -1, -1);
    check("t4_pulses", 16'(pulses), 16'd1);
    check("t4_ldata", cap_l, 16'h4321);
    check("t4_rdata", cap_r, 16'hFFF0);
    check("t4_short", {15'd0, short_word}, 16'd1);

    // Asynchronous reset during SHIFT, then realignment
    intf.out_ready = 1'b0;
    send_channel(1'b1, 16'h2468, 16, -1, -1);
    check("t5_pre_valid", {15'd0, intf.out_valid}, 16'd1);
    send_channel(1'b0, 16'h1357, 16, -1, 6);
    check("t5_rst_ldata", snap_l, 16'h0000);
    check("t5_rst_rdata", snap_r, 16'h0000);
    check("t5_rst_valid", {15'd0, snap_v}, 16'd0);
    check("t5_rst_overrun", {15'd0, snap_ov}, 16'd0);
    check("t5_rst_short", {15'd0, snap_sw}, 16'd0);
    intf.out_ready = 1'b1;
    pulses = 0;
    send_channel(1'b1, 16'h7777, 16, -1, -1);
    check("t5_no_frame_before_fall", 16'(pulses), 16'd0);
    send_channel(1'b0, 16'hAAAA, 16, -1, -1);
    send_channel(1'b1, 16'h5555, 16, -1, -1);
    tick(4);
    check("t5_pulses", 16'(pulses), 16'd1);
    check("t5_ldata", cap_l, 16'hAAAA);
    check("t5_rdata", cap_r, 16'h5555);
    check("t5_overrun_clear", {15'd0, overrun}, 16'd0);
    check("t5_short_clear", {15'd0, short_word}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Receive-side counterpart to the DAC serializer in the audio path.
- Deserializes the codec's ADC stream (AUD_ADCDAT framed by AUD_BCLK and AUD_ADCLRCK, codec is bit-clock master) into parallel 16-bit left/right samples in the CLOCK_50 domain.
- Presents each stereo frame through a valid/ready handshake for downstream effects (delay, filter) or the ADCDATA register.

Parameters:
- SAMPLE_W, 16, bits captured per channel, MSB first.
- I2S_DELAY, 1, BCLK rising edges skipped after each LRCK edge before the MSB (1 = I2S, 0 = left-justified).
- SYNC_STAGES, 2, flip-flops in each input synchronizer (minimum 2).

Ports:
- Clk, input, 1, system clock (CLOCK_50).
- Reset_n, input, 1, asynchronous active-low reset.
- Enable, input, 1, capture enable; low forces IDLE.
- AUD_BCLK, input, 1, codec bit clock (asynchronous to Clk).
- AUD_ADCLRCK, input, 1, codec ADC frame clock; low = left, high = right.
- AUD_ADCDAT, input, 1, codec serial ADC data.
- LDATA, output, SAMPLE_W, left sample, two's complement.
- RDATA, output, SAMPLE_W, right sample, two's complement.
- out_valid, output, 1, LDATA/RDATA hold a new frame.
- out_ready, input, 1, consumer accepts the frame.
- overrun, output, 1, sticky: a frame was overwritten before it was accepted.
- short_word, output, 1, sticky: a channel ended before SAMPLE_W bits were captured.

Behaviour:
- Reset: LDATA=0, RDATA=0, out_valid=0, overrun=0, short_word=0. All synchronizers clear to 0. FSM goes to IDLE.
- Synchronization: BCLK, ADCLRCK and ADCDAT each pass through SYNC_STAGES flops. A BCLK rise is detected as synced value 1 with previous synced value 0. An LRCK edge is any change in the synced LRCK, evaluated on a BCLK rise. All logic runs on Clk; BCLK never clocks a flop.
- FSM states IDLE, ALIGN, SKIP, SHIFT, WAIT:
  - IDLE: while Enable=0. Enable=1 moves to ALIGN.
  - ALIGN: wait for an LRCK falling edge (start of left channel), so capture never begins mid-frame. Go to SKIP, or to SHIFT if I2S_DELAY=0.
  - SKIP: count I2S_DELAY BCLK rises, then SHIFT.
  - SHIFT: on each BCLK rise, shift synced ADCDAT into the channel shift register MSB first and increment the bit counter. When the counter reaches SAMPLE_W, store the word in the channel hold register and go to WAIT.
  - WAIT: ignore further bits until an LRCK edge.
- LRCK edge during SHIFT (short channel): left-align the captured bits, zero-fill the LSBs, store the word, set short_word. The edge then starts the next channel exactly as in WAIT.
- LRCK edge in SHIFT or WAIT: switch channel, clear the counter, enter SKIP/SHIFT.
- Frame completion:
  - When the right word is stored, LDATA/RDATA load both hold registers on the next Clk and out_valid rises.
  - Latency: out_valid rises SYNC_STAGES+2 Clk after the pin-level BCLK rise carrying the final right bit.
- Handshake:
  - out_valid stays high and LDATA/RDATA stay stable until a Clk edge with out_valid && out_ready; out_valid then drops on that edge.
  - A new frame completing on the same edge as acceptance loads the new frame and keeps out_valid high; no overrun.
  - A new frame completing while out_valid=1 and out_ready=0 overwrites LDATA/RDATA and sets overrun.
- Enable fall at any point: FSM goes to IDLE, partial words are discarded, LDATA/RDATA/out_valid are unchanged, and sticky flags persist. Only Reset_n clears sticky flags.
- Bit counter saturates at SAMPLE_W; codec word lengths above SAMPLE_W truncate the LSBs.

Optional Feature:
- Macro ADC_DCBLOCK_EN.
- Defined:
  - Each channel passes through a one-pole DC blocker before LDATA/RDATA: y = x − x_prev + y_prev − (y_prev >>> 8).
  - Intermediate width is SAMPLE_W+2, saturated to the SAMPLE_W signed range.
  - State updates only on frame completion and resets to 0.
  - Adds exactly 1 Clk to out_valid latency.
- Undefined: raw samples, no extra latency, no filter registers.

Decomposition:
- Package adc_pkg:
  - Default SAMPLE_W.
  - State enum typedef adc_state_t (IDLE, ALIGN, SKIP, SHIFT, WAIT).
  - Channel enum (CH_LEFT, CH_RIGHT).
  - DC-block shift constant DCB_SHIFT=8.
- Sub-module sync_edge: SYNC_STAGES-flop synchronizer with rise/fall/level outputs, instantiated for BCLK, ADCLRCK and ADCDAT.

Test Plan:
- I2S frame, BCLK = Clk/16, left 16'hA5C3, right 16'h0F0F, out_ready=1 → one out_valid pulse; LDATA=A5C3, RDATA=0F0F, latency 4 Clk after last right bit.
- Enable raised mid-right-channel → first partial frame discarded; first out_valid carries the next full frame.
- out_ready=0 across two frames (1234/5678, then 9ABC/DEF0) → LDATA=9ABC, RDATA=DEF0, overrun=1; out_ready=1 for 1 Clk → out_valid=0.
- Right channel of 12 bits 0xFFF → RDATA=16'hFFF0, short_word=1.
- Reset_n pulsed low mid-SHIFT → all outputs 0 immediately (asynchronous); capture resumes only after the next LRCK fall.
- ADC_DCBLOCK_EN defined, constant input 16'h4000 both channels → first output 4000, outputs decay toward 0 within 2000 frames, out_valid latency 5 Clk.
